// File: rtl/i2c_write_master.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_write_master
//  Description : Single-master I2C write engine. Sends START, an address
//                byte and a stream of data bytes over valid/ready, checks
//                the slave ACK after each byte, then STOP.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_write_master #(
    parameter int CLK_DIV   = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Start,
    input  logic [7:0] Addr,
    input  logic [7:0] Data_IN,
    input  logic       Data_Valid,
    input  logic       Data_Last,
    output logic       Data_Ready,
    output logic       SCL,
    inout  wire        SDA,
    output logic       Busy,
    output logic       Done,
    output logic       Ack_Err
);

    localparam int                 c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_max = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_one = c_div_w'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_ADDR     = 3'd2,
        S_ADDR_ACK = 3'd3,
        S_LOAD     = 3'd4,
        S_DATA     = 3'd5,
        S_DATA_ACK = 3'd6,
        S_STOP     = 3'd7
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_div_w-1:0]   r_div;
    logic [1:0]           r_q;
    logic [2:0]           r_bit;
    logic [7:0]           r_byte;
    logic                 r_last;
    logic                 r_sda_in;
    logic                 r_ack_err;
    logic                 r_done;

    logic                 w_timed;
    logic                 w_q_end;
    logic                 w_bit_end;
    logic                 w_ack_state;
    logic                 w_sample;
    logic                 w_tx_bit;
    logic                 w_scl;
    logic                 w_sda_low;
    logic                 w_ready;
    logic                 w_accept;

    // IDLE and LOAD have no bit timing; every other state runs the quarter counter
    assign w_timed     = (r_state != S_IDLE) && (r_state != S_LOAD);
    assign w_q_end     = (r_div == c_div_max);
    assign w_bit_end   = w_timed && w_q_end && (r_q == 2'd3);
    assign w_ack_state = (r_state == S_ADDR_ACK) || (r_state == S_DATA_ACK);
    assign w_sample    = w_ack_state && w_q_end && (r_q == 2'd2);
    assign w_accept    = (r_state == S_IDLE) && Start && !r_done;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_tx_bit = r_byte[r_bit];
        end else begin : g_msb_first
            assign w_tx_bit = r_byte[3'd7 - r_bit];
        end
    endgenerate

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_scl     = 1'b1;
        w_sda_low = 1'b0;
        w_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_START;
            end
            S_START: begin
                w_scl     = (r_q != 2'd3);
                w_sda_low = r_q[1];
                if (w_bit_end) w_next = S_ADDR;
            end
            S_ADDR: begin
                w_scl     = r_q[0] ^ r_q[1];
                w_sda_low = !w_tx_bit;
                if (w_bit_end && (r_bit == 3'd7)) w_next = S_ADDR_ACK;
            end
            S_ADDR_ACK: begin
                w_scl = r_q[0] ^ r_q[1];
                if (w_bit_end) w_next = r_sda_in ? S_STOP : S_LOAD;
            end
            S_LOAD: begin
                // bus is stretched with SCL low until a byte is offered
                w_scl   = 1'b0;
                w_ready = 1'b1;
                if (Data_Valid) w_next = S_DATA;
            end
            S_DATA: begin
                w_scl     = r_q[0] ^ r_q[1];
                w_sda_low = !w_tx_bit;
                if (w_bit_end && (r_bit == 3'd7)) w_next = S_DATA_ACK;
            end
            S_DATA_ACK: begin
                w_scl = r_q[0] ^ r_q[1];
                if (w_bit_end) w_next = (r_sda_in || r_last) ? S_STOP : S_LOAD;
            end
            S_STOP: begin
                w_scl     = (r_q != 2'd0);
                w_sda_low = (r_q != 2'd3);
                if (w_bit_end) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_div     <= '0;
            r_q       <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_last    <= 1'b0;
            r_sda_in  <= 1'b1;
            r_ack_err <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == S_STOP) && w_bit_end;

            if (w_timed && !w_q_end) r_div <= r_div + c_div_one;
            else                     r_div <= '0;

            if (!w_timed)     r_q <= '0;
            else if (w_q_end) r_q <= r_q + 2'd1;

            if (w_bit_end && ((r_state == S_ADDR) || (r_state == S_DATA)))
                r_bit <= r_bit + 3'd1;

            if (w_sample) r_sda_in <= SDA;

            if (w_accept) begin
                r_byte    <= Addr;
                r_ack_err <= 1'b0;
            end

            if ((r_state == S_LOAD) && Data_Valid) begin
                r_byte <= Data_IN;
                r_last <= Data_Last;
            end

            if (w_ack_state && w_bit_end && r_sda_in) r_ack_err <= 1'b1;
        end
    end

    assign SDA        = w_sda_low ? 1'b0 : 1'bz;
    assign SCL        = w_scl;
    assign Data_Ready = w_ready;
    assign Busy       = (r_state != S_IDLE);
    assign Done       = r_done;
    assign Ack_Err    = r_ack_err;

endmodule
`default_nettype wire

// File: tb/tb_i2c_write_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_write_master
//  Description : Self-checking bench with an I2C slave model, a byte source
//                and a transaction-level reference for i2c_write_master.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_write_master;

    localparam int CLK_DIV = 4;

    logic       clk        = 1'b0;
    logic       rstn       = 1'b0;
    logic       start      = 1'b0;
    logic [7:0] addr       = 8'h00;
    logic [7:0] data_in    = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_last  = 1'b0;
    logic       data_ready, scl, busy, done, ack_err;
    wire        sda_bus;
    logic       slv_low    = 1'b0;

    pullup (sda_bus);
    assign sda_bus = slv_low ? 1'b0 : 1'bz;

    // second instance: MSB-first, no slave attached (address is NACKed)
    logic       start2     = 1'b0;
    logic [7:0] addr2      = 8'h00;
    logic       ready2, scl2, busy2, done2, err2;
    wire        sda2;
    pullup (sda2);

    always #5 clk = ~clk;

    i2c_write_master #(.CLK_DIV(CLK_DIV), .LSB_FIRST(1'b1)) u_dut (
        .CLK(clk), .RSTn(rstn), .Start(start), .Addr(addr),
        .Data_IN(data_in), .Data_Valid(data_valid), .Data_Last(data_last),
        .Data_Ready(data_ready), .SCL(scl), .SDA(sda_bus),
        .Busy(busy), .Done(done), .Ack_Err(ack_err)
    );

    i2c_write_master #(.CLK_DIV(2), .LSB_FIRST(1'b0)) u_dut_msb (
        .CLK(clk), .RSTn(rstn), .Start(start2), .Addr(addr2),
        .Data_IN(8'h00), .Data_Valid(1'b0), .Data_Last(1'b0),
        .Data_Ready(ready2), .SCL(scl2), .SDA(sda2),
        .Busy(busy2), .Done(done2), .Ack_Err(err2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    bit   rx_q[$];
    int   n_start = 0, n_stop = 0, n_ack_slots = 0;
    int   nack_frame = -1;
    int   slv_bits = 0, slv_byte = 0;
    logic prev_scl = 1'b1, prev_sda = 1'b1;

    always @(negedge clk) begin
        logic s_scl, s_sda;
        s_scl = scl;
        s_sda = sda_bus;
        if (prev_scl && s_scl && prev_sda && !s_sda) begin
            n_start++;
            slv_bits = 0;
            slv_byte = 0;
            slv_low  = 1'b0;
        end else if (prev_scl && s_scl && !prev_sda && s_sda) begin
            n_stop++;
            for (int i = 0; i < slv_bits; i++)
                if (rx_q.size() > 0) void'(rx_q.pop_back());
            slv_bits = 0;
        end else if (!prev_scl && s_scl) begin
            if (slv_bits < 8) begin
                rx_q.push_back(s_sda);
                slv_bits++;
            end else begin
                n_ack_slots++;
                slv_byte++;
                slv_bits = 0;
            end
        end else if (prev_scl && !s_scl) begin
            slv_low = (slv_bits == 8) && (slv_byte != nack_frame);
        end
        prev_scl = s_scl;
        prev_sda = s_sda;
    end

    // ---------------- byte source ----------------
    logic [7:0] src_q[$];
    int   src_idx = 0, stall_sel = 99, stall_left = 0, n_hs = 0;
    bit   pend = 1'b0, ready_seen = 1'b0, scl_in_stall = 1'b0;

    always @(negedge clk) begin
        if (pend) begin
            src_idx++;
            n_hs++;
            pend = 1'b0;
        end
        if (data_ready) ready_seen = 1'b1;
        data_valid = 1'b0;
        if (src_idx < src_q.size()) begin
            if (src_idx == stall_sel && stall_left > 0 && data_ready) begin
                stall_left--;
                if (scl) scl_in_stall = 1'b1;
            end else begin
                data_valid = 1'b1;
                data_in    = src_q[src_idx];
                data_last  = (src_idx == src_q.size() - 1);
            end
        end
        pend = data_valid && data_ready;
    end

    // ---------------- MSB instance monitor ----------------
    bit   q2[$];
    logic p_scl2 = 1'b1;
    bit   ready2_seen = 1'b0;
    always @(negedge clk) begin
        if (!p_scl2 && scl2) q2.push_back(sda2);
        if (ready2) ready2_seen = 1'b1;
        p_scl2 = scl2;
    end

    // ---------------- transaction runner + reference ----------------
    logic [7:0] txn_data[8];

    task automatic run_txn(input logic [7:0] addr_i, input int n, input bit addr_nack,
                           input int nack_idx, input int stall_idx, input bit busy_poke,
                           input int rst_at);
        int sent, stall_cl, exp_done, done_at, c;
        bit exp_err;
        rx_q.delete();
        n_start = 0; n_stop = 0; n_ack_slots = 0; n_hs = 0;
        ready_seen = 1'b0; scl_in_stall = 1'b0;
        nack_frame = addr_nack ? 0 : ((nack_idx < n) ? nack_idx + 1 : -1);
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back(txn_data[i]);
        src_idx = 0; stall_sel = stall_idx; stall_left = 50; pend = 1'b0;

        addr  = addr_i;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        c       = 0;
        done_at = -1;
        while (done_at < 0 && c < 3000) begin
            if (rst_at > 0 && c == rst_at) begin
                rstn = 1'b0;
                #1;
                check("rst_mid_scl", scl, 1);
                check("rst_mid_sda", sda_bus, 1);
                check("rst_mid_busy", busy, 0);
                check("rst_mid_done", done, 0);
                check("rst_mid_err", ack_err, 0);
                @(negedge clk);
                rstn = 1'b1;
                src_q.delete();
                @(negedge clk);
                return;
            end
            if (done) begin
                done_at = c;
            end else begin
                start = busy_poke && (c == 100);
                addr  = start ? ~addr_i : addr_i;
                @(negedge clk);
                c++;
            end
        end
        check("done_seen", done_at >= 0, 1);
        if (done_at >= 0) begin
            start = 1'b1;
            addr  = addr_i ^ 8'h5A;
            @(negedge clk);
            start = 1'b0;
            check("start_on_done_busy", busy, 0);
            check("done_width", done, 0);
        end

        sent     = addr_nack ? 0 : ((nack_idx < n) ? nack_idx + 1 : n);
        stall_cl = (stall_idx < sent) ? 50 : 0;
        exp_err  = addr_nack || (nack_idx < n);
        exp_done = 4 * CLK_DIV * (2 + 9 * (1 + sent)) + sent + stall_cl;

        check("done_cycle", done_at, exp_done);
        check("handshakes", n_hs, sent);
        check("ack_slots", n_ack_slots, 1 + sent);
        check("starts", n_start, 1);
        check("stops", n_stop, 1);
        check("ack_err", ack_err, exp_err);
        check("rx_bits", rx_q.size(), 8 * (1 + sent));
        for (int k = 0; k <= sent; k++) begin
            logic [7:0] got_b, exp_b;
            got_b = '0;
            for (int i = 0; i < 8; i++)
                if (8 * k + i < rx_q.size()) got_b[i] = rx_q[8 * k + i];
            exp_b = (k == 0) ? addr_i : txn_data[k - 1];
            check("rx_byte", got_b, exp_b);
        end
        if (addr_nack) check("ready_on_addr_nack", ready_seen, 0);
        if (stall_cl > 0) check("scl_high_in_stall", scl_in_stall, 0);
        src_q.delete();
        @(negedge clk);
    endtask

    task automatic run_msb();
        int c;
        logic [7:0] got_b;
        q2.delete();
        ready2_seen = 1'b0;
        addr2  = 8'hA5;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        c = 0;
        while (!done2 && c < 1000) begin
            start2 = (c == 20);
            addr2  = start2 ? 8'h00 : 8'hA5;
            @(negedge clk);
            c++;
        end
        start2 = 1'b0;
        check("msb_done_cycle", c, 4 * 2 * (2 + 9));
        got_b = '0;
        for (int i = 0; i < 8; i++)
            if (i < q2.size()) got_b[7 - i] = q2[i];
        check("msb_addr_order", got_b, 8'hA5);
        check("msb_scl_pulses", q2.size(), 10);
        check("msb_ack_err", err2, 1);
        check("msb_ready", ready2_seen, 0);
        @(negedge clk);
        check("msb_idle_busy", busy2, 0);
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_scl", scl, 1);
        check("rst_sda", sda_bus, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", ack_err, 0);
        check("rst_ready", data_ready, 0);
        rstn = 1'b1;
        @(negedge clk);

        txn_data[0] = 8'hA5;
        run_txn(8'h33, 1, 1'b0, 99, 99, 1'b0, 0);
        run_txn(8'h34, 1, 1'b1, 99, 99, 1'b0, 0);
        txn_data[0] = 8'h01; txn_data[1] = 8'h02; txn_data[2] = 8'h03;
        run_txn(8'h5A, 3, 1'b0, 99, 1, 1'b0, 0);
        run_txn(8'h5A, 3, 1'b0, 1, 99, 1'b0, 0);
        run_txn(8'h21, 3, 1'b0, 99, 99, 1'b0, 200);
        run_txn(8'h21, 3, 1'b0, 99, 99, 1'b1, 0);
        run_msb();

        for (int t = 0; t < 10; t++) begin
            int         n, nk, st;
            bit         an, bp;
            logic [7:0] a;
            n  = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) txn_data[i] = 8'($urandom);
            a  = 8'($urandom);
            an = ($urandom_range(0, 5) == 0);
            nk = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : 99;
            st = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : 99;
            bp = ($urandom_range(0, 1) == 1);
            run_txn(a, n, an, nk, st, bp, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Synthesizable single-master I2C write engine that generates SCL and drives open-drain SDA toward the team's I2C slave receiver.
- Sends START, one 8-bit address byte, then a stream of data bytes taken over a valid/ready handshake, checking the slave's ACK after every byte, then STOP.
- Sits directly upstream of the slave. Bit order defaults to LSB-first to match the slave's shift direction.

Parameters:
- CLK_DIV, 4: system clocks per SCL quarter-period; must be ≥1. One SCL bit period is 4*CLK_DIV clocks.
- LSB_FIRST, 1: 1 = bit 0 of each byte is sent first; 0 = MSB first.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RSTn  input  1  asynchronous active-low reset.
- Start  input  1  single-cycle request to begin a transaction; ignored while Busy=1.
- Addr  input  8  address byte, captured on Start.
- Data_IN  input  8  data byte offered to the master.
- Data_Valid  input  1  Data_IN/Data_Last are valid.
- Data_Last  input  1  marks the final byte of the transaction.
- Data_Ready  output  1  master is accepting a byte; transfer occurs when Valid&&Ready.
- SCL  output  1  I2C clock, push-pull, idle high.
- SDA  inout  1  open-drain: driven 0 or released to Z; read back for ACK.
- Busy  output  1  high from Start accept until return to IDLE.
- Done  output  1  one-cycle pulse on return to IDLE after STOP.
- Ack_Err  output  1  set on any NACK; cleared on the next accepted Start.

Behaviour:
- Reset (async): state=IDLE, SCL=1, SDA released (Z), Data_Ready=0, Busy=0, Done=0, Ack_Err=0, counters=0.
- A reset mid-transaction releases SDA and raises SCL immediately. No STOP is generated; the next START resynchronises the slave.
- Quarter-phase counter q0..q3, each q lasting CLK_DIV clocks.
- In bit states (ADDR, DATA, ACK): SCL=0 in q0 and q3, SCL=1 in q1 and q2.
- SDA changes only at the q0 boundary. SDA is sampled on the last clock of q2.
- SDA drive rule: a "1" bit is released (Z) and a "0" bit is driven low.
- States and transitions:
  - IDLE: SCL=1, SDA=Z. On Start, capture Addr, clear Ack_Err, set Busy, go to START.
  - START: q0–q1 SCL=1, SDA=Z; q2 SCL=1, SDA=0 (START condition); q3 SCL=0. Then go to ADDR.
  - ADDR: 8 bit periods shifting the address byte per LSB_FIRST. Then go to ADDR_ACK.
  - ADDR_ACK: SDA released for one bit period and sampled in q2. Sample 0 (ACK) → LOAD. Sample 1 (NACK) → set Ack_Err, go to STOP.
  - LOAD: SCL held 0, SDA held, Data_Ready=1. On Valid&&Ready, capture Data_IN and Data_Last, drop Ready the next cycle, go to DATA. Stays in LOAD indefinitely while Valid=0 (bus stretched low). Minimum dwell is 1 clock.
  - DATA: 8 bit periods. Then go to DATA_ACK.
  - DATA_ACK: as ADDR_ACK. On ACK: captured Last=1 → STOP, Last=0 → LOAD. On NACK: set Ack_Err, go to STOP; remaining bytes are not requested.
  - STOP: q0 SCL=0, SDA=0; q1–q2 SCL=1, SDA=0; q3 SCL=1, SDA=Z (STOP condition). Then go to IDLE with Done=1 for one clock and Busy=0.
- Data_Ready is high only in LOAD.
- Start while Busy is ignored. Start in the same cycle Done pulses is ignored; a new Start is accepted from the following cycle.
- Bit counter wraps 7→0 per byte. There is no limit on the number of data bytes.
- Timing for N data bytes with Valid already high: (2 + 9*(N+1)) bit periods plus N LOAD clocks.

Test Plan:
- CLK_DIV=4, Start with Addr=0x33, Data_IN=0xA5 with Last=1, slave ACKs both bytes.
  - SDA seen at SCL rise: 1,1,0,0,1,1,0,0 | ACK | 1,0,1,0,0,1,0,1 | ACK.
  - START/STOP edges occur with SCL high. Done pulses at 320+1 clocks after the START state is entered. Ack_Err=0.
- Address NACK (Addr=0x34, slave silent, pull-up high): Ack_Err=1 after the 9th SCL pulse, Data_Ready never asserts, STOP issued, Done pulses.
- Three bytes 0x01, 0x02, 0x03 with Valid held low for 50 clocks before byte 2:
  - SCL stays 0 throughout the stall.
  - Exactly 3 Ready&&Valid handshakes, 4 ACK slots, then STOP.
- Data NACK on byte 2 of 3: Ack_Err=1, STOP immediately after the byte-2 ACK slot, byte 3 never requested.
- Reset asserted in the middle of DATA: SCL=1 and SDA=Z within the same cycle, Busy=0, Done=0. A fresh transaction after reset completes normally.
- LSB_FIRST=0, byte 0xA5: SDA order 1,0,1,0,0,1,0,1. Start pulsed while Busy has no effect on the transaction.
